// File: rtl/round_key_reader_pkg.sv
// Shared types and constants for the round-key reader: FSM encoding, key/word/address
// widths and the AES round counts per key size.
package round_key_reader_pkg;

  localparam int KEY_W          = 128;
  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 4;
  localparam int AES_ROUNDS_128 = 10;
  localparam int AES_ROUNDS_192 = 12;
  localparam int AES_ROUNDS_256 = 14;

  typedef logic [KEY_W-1:0]  keyT;
  typedef logic [WORD_W-1:0] wordT;
  typedef logic [ADDR_W-1:0] addrT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } stateT;

  // A buffered key remembers which round it belongs to.
  typedef struct packed {
    addrT round;
    keyT  data;
  } keyEntryT;

  // Bank 1 lands in the most significant word.
  function automatic keyT packKey(input wordT w1, input wordT w2, input wordT w3, input wordT w4);
    return {w1, w2, w3, w4};
  endfunction

endpackage

// File: rtl/round_key_prefetch_buf.sv
// Two-entry valid/ready buffer that holds prefetched round keys ahead of the consumer.
module round_key_prefetch_buf #(
  parameter int WIDTH = 132
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oFull
);

  localparam int DEPTH = 2;

  logic [WIDTH-1:0] memReg [DEPTH];
  logic             wrPtrReg;
  logic             rdPtrReg;
  logic [1:0]       countReg;
  logic             push;
  logic             pop;

  assign oValid = (countReg != 2'd0);
  assign oFull  = (countReg == 2'(DEPTH));
  assign oData  = memReg[rdPtrReg];
  assign pop    = oValid & iReady;
  // A write into a full buffer is only safe when the head leaves on the same edge.
  assign push   = iPush & (~oFull | pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          memReg[gi] <= '0;
        end else if (push && (wrPtrReg == 1'(gi))) begin
          memReg[gi] <= iData;
        end
      end
    end
  endgenerate

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtrReg <= 1'b0;
      rdPtrReg <= 1'b0;
      countReg <= 2'd0;
    end else begin
      wrPtrReg <= wrPtrReg ^ push;
      rdPtrReg <= rdPtrReg ^ pop;
      countReg <= countReg + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/round_key_reader.sv
// Reads round keys 0..iRound from the Ke or Kd bank RAMs and presents them over valid/ready.
// Optional read-ahead through a 2-entry buffer when ROUND_KEY_READER_PREFETCH_EN is defined.
module round_key_reader
  import round_key_reader_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int MAX_ROUND   = 14
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iDecrypt,
  input  logic [ADDR_W-1:0] iRound,
  input  logic              iKeys_valid,
  output logic [ADDR_W-1:0] oRAM_Ke_addr,
  output logic              oRAM_Ke_rd,
  input  logic [WORD_W-1:0] iRAM_Ke_data_1,
  input  logic [WORD_W-1:0] iRAM_Ke_data_2,
  input  logic [WORD_W-1:0] iRAM_Ke_data_3,
  input  logic [WORD_W-1:0] iRAM_Ke_data_4,
  output logic [ADDR_W-1:0] oRAM_Kd_addr,
  output logic              oRAM_Kd_rd,
  input  logic [WORD_W-1:0] iRAM_Kd_data_1,
  input  logic [WORD_W-1:0] iRAM_Kd_data_2,
  input  logic [WORD_W-1:0] iRAM_Kd_data_3,
  input  logic [WORD_W-1:0] iRAM_Kd_data_4,
  output logic              oKey_valid,
  input  logic              iKey_ready,
  output logic [KEY_W-1:0]  oKey_data,
  output logic [ADDR_W-1:0] oKey_round,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam addrT MAX_ROUND_A = addrT'(MAX_ROUND);

  stateT state;
  addrT  roundReg;
  addrT  addrReg;
  logic  decryptReg;
  logic  rdReg;
  logic  busyReg;
  logic  doneReg;
  logic  errReg;
  keyT   keKey;
  keyT   kdKey;
  keyT   ramKey;
  logic  startReq;
  logic  roundOk;

  assign keKey    = packKey(iRAM_Ke_data_1, iRAM_Ke_data_2, iRAM_Ke_data_3, iRAM_Ke_data_4);
  assign kdKey    = packKey(iRAM_Kd_data_1, iRAM_Kd_data_2, iRAM_Kd_data_3, iRAM_Kd_data_4);
  assign ramKey   = decryptReg ? kdKey : keKey;
  assign startReq = iStart & iKeys_valid;
  assign roundOk  = (iRound <= MAX_ROUND_A);

  // Only the selected RAM ever sees a strobe or a non-zero address.
  assign oRAM_Ke_rd   = rdReg & ~decryptReg;
  assign oRAM_Kd_rd   = rdReg & decryptReg;
  assign oRAM_Ke_addr = (busyReg & ~decryptReg) ? addrReg : '0;
  assign oRAM_Kd_addr = (busyReg & decryptReg) ? addrReg : '0;
  assign oBusy        = busyReg;
  assign oDone        = doneReg;
  assign oErr         = errReg;

`ifdef ROUND_KEY_READER_PREFETCH_EN

  localparam logic [1:0] BUF_DEPTH = 2'd2;

  logic [RAM_LATENCY-1:0] pipeReg;
  addrT                   issueAddrReg;
  addrT                   pushRoundReg;
  logic [1:0]             creditReg;
  logic                   bufValid;
  logic                   bufFull;
  logic                   push;
  logic                   pop;
  logic                   startIssue;
  logic                   canIssue;
  logic                   issueNow;
  keyEntryT               pushEntry;
  keyEntryT               bufOut;

  assign push             = pipeReg[RAM_LATENCY-1];
  assign pop              = bufValid & iKey_ready;
  assign pushEntry.round  = pushRoundReg;
  assign pushEntry.data   = ramKey;
  assign startIssue       = (state == ST_IDLE) & startReq & roundOk;
  // A credit covers a key from its read strobe until the consumer takes it.
  assign canIssue         = (state == ST_ISSUE) && ((creditReg < BUF_DEPTH) || pop) && (~bufFull || pop);
  assign issueNow         = startIssue | canIssue;

  round_key_prefetch_buf #(
    .WIDTH($bits(keyEntryT))
  ) uPrefetchBuf (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iPush  (push),
    .iData  (pushEntry),
    .oValid (bufValid),
    .iReady (iKey_ready),
    .oData  (bufOut),
    .oFull  (bufFull)
  );

  assign oKey_valid = bufValid;
  assign oKey_data  = bufOut.data;
  assign oKey_round = bufOut.round;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= ST_IDLE;
      roundReg     <= '0;
      addrReg      <= '0;
      decryptReg   <= 1'b0;
      rdReg        <= 1'b0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      errReg       <= 1'b0;
      pipeReg      <= '0;
      issueAddrReg <= '0;
      pushRoundReg <= '0;
      creditReg    <= 2'd0;
    end else begin
      rdReg     <= 1'b0;
      doneReg   <= 1'b0;
      errReg    <= 1'b0;
      pipeReg   <= (pipeReg << 1) | RAM_LATENCY'(rdReg);
      creditReg <= creditReg + 2'(issueNow) - 2'(pop);
      if (push) begin
        pushRoundReg <= pushRoundReg + addrT'(1);
      end
      unique case (state)
        ST_IDLE: begin
          if (startReq && roundOk) begin
            roundReg     <= iRound;
            decryptReg   <= iDecrypt;
            addrReg      <= '0;
            rdReg        <= 1'b1;
            issueAddrReg <= addrT'(1);
            pushRoundReg <= '0;
            busyReg      <= 1'b1;
            state        <= (iRound == '0) ? ST_WAIT : ST_ISSUE;
          end else if (startReq) begin
            errReg <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (canIssue) begin
            addrReg      <= issueAddrReg;
            rdReg        <= 1'b1;
            issueAddrReg <= issueAddrReg + addrT'(1);
            if (issueAddrReg == roundReg) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // All reads are out; finish once the last round leaves the buffer.
          if (pop && (bufOut.round == roundReg)) begin
            doneReg <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busyReg <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`else

  localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

  logic [1:0] waitCntReg;
  keyT        keyDataReg;
  addrT       keyRoundReg;
  logic       keyValidReg;

  assign oKey_valid = keyValidReg;
  assign oKey_data  = keyDataReg;
  assign oKey_round = keyRoundReg;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= ST_IDLE;
      roundReg    <= '0;
      addrReg     <= '0;
      decryptReg  <= 1'b0;
      rdReg       <= 1'b0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      errReg      <= 1'b0;
      waitCntReg  <= 2'd0;
      keyDataReg  <= '0;
      keyRoundReg <= '0;
      keyValidReg <= 1'b0;
    end else begin
      rdReg   <= 1'b0;
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (startReq && roundOk) begin
            roundReg   <= iRound;
            decryptReg <= iDecrypt;
            addrReg    <= '0;
            rdReg      <= 1'b1;
            busyReg    <= 1'b1;
            state      <= ST_ISSUE;
          end else if (startReq) begin
            errReg <= 1'b1;
          end
        end
        ST_ISSUE: begin
          waitCntReg <= 2'd0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (waitCntReg == LAT_LAST) begin
            keyDataReg  <= ramKey;
            keyRoundReg <= addrReg;
            keyValidReg <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            waitCntReg <= waitCntReg + 2'd1;
          end
        end
        ST_HOLD: begin
          if (iKey_ready) begin
            keyValidReg <= 1'b0;
            if (addrReg == roundReg) begin
              doneReg <= 1'b1;
              state   <= ST_DONE;
            end else begin
              addrReg <= addrReg + addrT'(1);
              rdReg   <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          busyReg <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_round_key_reader.sv
// Directed bench for round_key_reader: table of start requests plus hand-written reset sequence.
`timescale 1ns/1ps
module tb_round_key_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, decrypt, keysValid, keyReady, useSlow;
  logic [3:0] round;

  // Instance A: RAM latency 1; instance B: RAM latency 3
  logic         aStart, aKeRd, aKdRd, aValid, aBusy, aDone, aErr;
  logic [3:0]   aKeAddr, aKdAddr, aRound;
  logic [127:0] aKeQ, aKdQ, aData;
  logic         bStart, bKeRd, bKdRd, bValid, bBusy, bDone, bErr;
  logic [3:0]   bKeAddr, bKdAddr, bRound;
  logic [127:0] bKeP [3];
  logic [127:0] bKdP [3];
  logic [127:0] bData;

  assign aStart = start & ~useSlow;
  assign bStart = start & useSlow;

  localparam logic [127:0] POISON = {4{32'hDEAD_BEEF}};

  function automatic logic [127:0] keyPat(input logic dec, input logic [3:0] r);
    logic [31:0] rr;
    rr = {28'd0, r};
    if (dec) return {32'h1100_0000 + rr, 32'h2200_0000 + rr, 32'h3300_0000 + rr, 32'h4400_0000 + rr};
    return {32'hA000_0000 + rr, 32'hB000_0000 + rr, 32'hC000_0000 + rr, 32'hD000_0000 + rr};
  endfunction

  // RAM models: data valid exactly RAM_LATENCY cycles after the strobe, garbage otherwise
  always @(posedge clk) begin
    aKeQ    <= aKeRd ? keyPat(1'b0, aKeAddr) : POISON;
    aKdQ    <= aKdRd ? keyPat(1'b1, aKdAddr) : POISON;
    bKeP[0] <= bKeRd ? keyPat(1'b0, bKeAddr) : POISON;
    bKdP[0] <= bKdRd ? keyPat(1'b1, bKdAddr) : POISON;
    bKeP[1] <= bKeP[0];
    bKeP[2] <= bKeP[1];
    bKdP[1] <= bKdP[0];
    bKdP[2] <= bKdP[1];
  end

  round_key_reader #(.RAM_LATENCY(1), .MAX_ROUND(14)) dutA (
    .iClk(clk), .iRst_n(rst_n), .iStart(aStart), .iDecrypt(decrypt), .iRound(round),
    .iKeys_valid(keysValid),
    .oRAM_Ke_addr(aKeAddr), .oRAM_Ke_rd(aKeRd),
    .iRAM_Ke_data_1(aKeQ[127:96]), .iRAM_Ke_data_2(aKeQ[95:64]),
    .iRAM_Ke_data_3(aKeQ[63:32]), .iRAM_Ke_data_4(aKeQ[31:0]),
    .oRAM_Kd_addr(aKdAddr), .oRAM_Kd_rd(aKdRd),
    .iRAM_Kd_data_1(aKdQ[127:96]), .iRAM_Kd_data_2(aKdQ[95:64]),
    .iRAM_Kd_data_3(aKdQ[63:32]), .iRAM_Kd_data_4(aKdQ[31:0]),
    .oKey_valid(aValid), .iKey_ready(keyReady), .oKey_data(aData), .oKey_round(aRound),
    .oBusy(aBusy), .oDone(aDone), .oErr(aErr)
  );

  round_key_reader #(.RAM_LATENCY(3), .MAX_ROUND(14)) dutB (
    .iClk(clk), .iRst_n(rst_n), .iStart(bStart), .iDecrypt(decrypt), .iRound(round),
    .iKeys_valid(keysValid),
    .oRAM_Ke_addr(bKeAddr), .oRAM_Ke_rd(bKeRd),
    .iRAM_Ke_data_1(bKeP[2][127:96]), .iRAM_Ke_data_2(bKeP[2][95:64]),
    .iRAM_Ke_data_3(bKeP[2][63:32]), .iRAM_Ke_data_4(bKeP[2][31:0]),
    .oRAM_Kd_addr(bKdAddr), .oRAM_Kd_rd(bKdRd),
    .iRAM_Kd_data_1(bKdP[2][127:96]), .iRAM_Kd_data_2(bKdP[2][95:64]),
    .iRAM_Kd_data_3(bKdP[2][63:32]), .iRAM_Kd_data_4(bKdP[2][31:0]),
    .oKey_valid(bValid), .iKey_ready(keyReady), .oKey_data(bData), .oKey_round(bRound),
    .oBusy(bBusy), .oDone(bDone), .oErr(bErr)
  );

  // View of whichever instance the current test drives
  logic         vKeRd, vKdRd, vValid, vBusy, vDone, vErr;
  logic [3:0]   vKeAddr, vKdAddr, vRound;
  logic [127:0] vData;
  assign vKeRd   = useSlow ? bKeRd   : aKeRd;
  assign vKdRd   = useSlow ? bKdRd   : aKdRd;
  assign vKeAddr = useSlow ? bKeAddr : aKeAddr;
  assign vKdAddr = useSlow ? bKdAddr : aKdAddr;
  assign vValid  = useSlow ? bValid  : aValid;
  assign vData   = useSlow ? bData   : aData;
  assign vRound  = useSlow ? bRound  : aRound;
  assign vBusy   = useSlow ? bBusy   : aBusy;
  assign vDone   = useSlow ? bDone   : aDone;
  assign vErr    = useSlow ? bErr    : aErr;

  int nCompared = 0;
  int nMismatch = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] rnd;
    logic       dec;
    logic       kv;
    bit         toggle;
    int         restartAt;
    bit         slow;
    int         expKeys;
    bit         expErr;
  } vecT;

  vecT vecs[8];

  task automatic runSeq(input int vi);
    vecT          v;
    int           nKeys, nDone, nErr, nSelRd, nOthRd, nOthAddr;
    int           firstValid, lastHs, doneAt, lat;
    bit           stallPrev, busyFirst;
    logic [127:0] heldData;
    logic [3:0]   heldRound;
    v = vecs[vi];
    nKeys = 0; nDone = 0; nErr = 0; nSelRd = 0; nOthRd = 0; nOthAddr = 0;
    firstValid = -1; lastHs = -1; doneAt = -1; stallPrev = 1'b0;
    heldData = '0; heldRound = '0;
    lat = v.slow ? 3 : 1;
    useSlow = v.slow;
    @(negedge clk);
    start = 1'b1; decrypt = v.dec; round = v.rnd; keysValid = v.kv; keyReady = 1'b1;
    @(negedge clk);
    // Perturb inputs after the start edge: the DUT must use its latched copies
    start = 1'b0; decrypt = ~v.dec; round = ~v.rnd; keysValid = 1'b0;
    busyFirst = vBusy;
    for (int c = 0; c < 200; c++) begin
      if (c == v.restartAt) begin
        start = 1'b1; keysValid = 1'b1;
      end else begin
        start = 1'b0; keysValid = 1'b0;
      end
      keyReady = v.toggle ? (c % 2 == 0) : 1'b1;
      if (vErr) nErr++;
      if (vDone) begin nDone++; doneAt = c; end
      if (v.dec ? vKdRd : vKeRd) begin
        check("rd_addr", v.dec ? vKdAddr : vKeAddr, 128'(nSelRd));
        nSelRd++;
      end
      if (v.dec ? vKeRd : vKdRd) nOthRd++;
      if ((v.dec ? vKeAddr : vKdAddr) != 4'd0) nOthAddr++;
      if (stallPrev) begin
        check("stall_valid", vValid, 1);
        check("stall_data", vData, heldData);
        check("stall_round", vRound, heldRound);
      end
      if (vValid && firstValid < 0) firstValid = c;
      stallPrev = vValid && !keyReady;
      if (stallPrev) begin heldData = vData; heldRound = vRound; end
      if (vValid && keyReady) begin
        $display("vec %0d key round=%0d data=%h", vi, vRound, vData);
        check("key_round", vRound, 128'(nKeys));
        check("key_data", vData, keyPat(v.dec, 4'(nKeys)));
        nKeys++;
        lastHs = c;
      end
      @(negedge clk);
    end
    start = 1'b0; keyReady = 1'b1;
    $display("vec %0d done: round=%0d dec=%0d keys=%0d err=%0d", vi, v.rnd, v.dec, nKeys, nErr);
    check("num_keys", 128'(nKeys), 128'(v.expKeys));
    check("num_done", 128'(nDone), (v.expKeys > 0) ? 128'd1 : 128'd0);
    check("num_err", 128'(nErr), 128'(v.expErr));
    check("sel_rd_count", 128'(nSelRd), 128'(v.expKeys));
    check("other_rd_count", 128'(nOthRd), 0);
    check("other_addr_nonzero", 128'(nOthAddr), 0);
    check("busy_after_start", busyFirst, (v.expKeys > 0) ? 128'd1 : 128'd0);
    check("busy_at_end", vBusy, 0);
    if (v.expKeys > 0) begin
      check("first_valid_latency", 128'(firstValid + 1), 128'(lat + 2));
      check("done_after_last_hs", 128'(doneAt), 128'(lastHs + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, cyc, nd;
    //          rnd    dec   kv    tog   restart slow keys err
    vecs[0] = '{4'd10, 1'b0, 1'b1, 1'b0, -1, 1'b0, 11, 1'b0};
    vecs[1] = '{4'd14, 1'b1, 1'b1, 1'b1, -1, 1'b0, 15, 1'b0};
    vecs[2] = '{4'd0,  1'b0, 1'b1, 1'b0, -1, 1'b0, 1,  1'b0};
    vecs[3] = '{4'd15, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0,  1'b1};
    vecs[4] = '{4'd5,  1'b0, 1'b0, 1'b0, -1, 1'b0, 0,  1'b0};
    vecs[5] = '{4'd3,  1'b1, 1'b1, 1'b0, 4,  1'b0, 4,  1'b0};
    vecs[6] = '{4'd10, 1'b0, 1'b1, 1'b1, -1, 1'b1, 11, 1'b0};
    vecs[7] = '{4'd2,  1'b1, 1'b1, 1'b0, -1, 1'b1, 3,  1'b0};

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; keysValid = 1'b0; keyReady = 1'b0;
    round = 4'd0; useSlow = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", {aValid, bValid}, 0);
    check("reset_data", aData | bData, 0);
    check("reset_round", {aRound, bRound}, 0);
    check("reset_flags", {aBusy, aDone, aErr, bBusy, bDone, bErr}, 0);
    check("reset_ram", {aKeRd, aKdRd, aKeAddr, aKdAddr, bKeRd, bKdRd, bKeAddr, bKdAddr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runSeq(i);

    // Reset while key 5 of 11 is in progress
    useSlow = 1'b0;
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; round = 4'd10; keysValid = 1'b1; keyReady = 1'b1;
    @(negedge clk);
    start = 1'b0; keysValid = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 4 && cyc < 100) begin
      if (vValid && keyReady) hs++;
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_key5", 128'(hs), 4);
    check("rst_busy_before", vBusy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", vBusy, 0);
    check("rst_async_valid", vValid, 0);
    check("rst_async_data", vData, 0);
    check("rst_async_round", vRound, 0);
    check("rst_async_ram", {vKeRd, vKdRd, vKeAddr, vKdAddr}, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (vDone) nd++;
    end
    check("rst_no_done", 128'(nd), 0);
    rst_n = 1'b1;
    runSeq(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
